// File: rtl/spiflash_cache_pkg.sv
// Shared types and constants for the direct-mapped SPI flash read cache.
package spiflash_cache_pkg;

  localparam int unsigned ADDR_W = 24;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_IDLE = 2'd1,
    ST_MISS = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  function automatic int unsigned calc_idx_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/spiflash_cache_ram.sv
// Line storage {tag, data}: asynchronous read, synchronous write, no reset.
module spiflash_cache_ram
  import spiflash_cache_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned IDX_W = 8,
  parameter int unsigned W     = 46
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [W-1:0]     wdata_i,
  output logic [W-1:0]     rdata_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/spiflash_cache.sv
// Direct-mapped word read cache in front of spimemio.
// Optional SPIFLASH_CACHE_STATS_EN adds hit_count/miss_count outputs.
module spiflash_cache
  import spiflash_cache_pkg::*;
#(
  parameter int unsigned DEPTH = 256
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              valid,
  output logic              ready,
  input  logic [ADDR_W-1:0] addr,
  output logic [31:0]       rdata,
  input  logic              flush,
  output logic              busy,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata
`ifdef SPIFLASH_CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned IDX_W = calc_idx_w(DEPTH);
  localparam int unsigned TAG_W = 22 - IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic                  ready_q, ready_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  mem_valid_q, mem_valid_d;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic                  busy_q, busy_d;
  logic [DEPTH-1:0]      vld_q;
  logic                  vld_clr, vld_set, ram_we;
  logic [TAG_W+31:0]     ram_rd;
  logic [IDX_W-1:0]      idx;
  logic [TAG_W-1:0]      tag;
  logic                  hit;
  logic                  unused_lsb;

  assign idx        = addr[IDX_W+1:2];
  assign tag        = addr[ADDR_W-1:IDX_W+2];
  assign hit        = vld_q[idx] && (ram_rd[TAG_W+31:32] == tag);
  assign unused_lsb = ^addr[1:0];

  spiflash_cache_ram #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W),
    .W     (TAG_W + 32)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .idx_i   (idx),
    .wdata_i ({tag, mem_rdata}),
    .rdata_o (ram_rd)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    ready_d     = 1'b0;
    rdata_d     = rdata_q;
    mem_valid_d = mem_valid_q;
    mem_addr_d  = mem_addr_q;
    busy_d      = busy_q;
    vld_clr     = 1'b0;
    vld_set     = 1'b0;
    ram_we      = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        vld_clr = 1'b1;
        if (flush) begin
          cnt_d = '0;
        end else if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_IDLE: begin
        // A pending or fresh flush beats any lookup; the request stays held upstream.
        if (pend_q || flush) begin
          state_d = ST_INIT;
          cnt_d   = '0;
          pend_d  = 1'b0;
          busy_d  = 1'b1;
        end else if (valid && hit) begin
          state_d = ST_RESP;
          ready_d = 1'b1;
          rdata_d = ram_rd[31:0];
        end else if (valid) begin
          state_d     = ST_MISS;
          mem_valid_d = 1'b1;
          mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
          busy_d      = 1'b1;
        end
      end
      ST_MISS: begin
        if (flush) pend_d = 1'b1;
        if (mem_ready) begin
          ram_we      = 1'b1;
          vld_set     = 1'b1;
          rdata_d     = mem_rdata;
          mem_valid_d = 1'b0;
          ready_d     = 1'b1;
          state_d     = ST_RESP;
        end
      end
      ST_RESP: begin
        if (flush) pend_d = 1'b1;
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      mem_valid_q <= mem_valid_d;
      mem_addr_q  <= mem_addr_d;
      busy_q      <= busy_d;
    end
  end

  // Line-valid bits are only meaningful after the sweep, so they carry no reset.
  always_ff @(posedge clk) begin
    if (vld_clr)      vld_q[cnt_q] <= 1'b0;
    else if (vld_set) vld_q[idx]   <= 1'b1;
  end

  assign ready     = ready_q;
  assign rdata     = rdata_q;
  assign busy      = busy_q;
  assign mem_valid = mem_valid_q;
  assign mem_addr  = mem_addr_q;

`ifdef SPIFLASH_CACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        hit_inc, miss_inc;

  assign hit_inc  = (state_q == ST_IDLE) && !pend_q && !flush && valid && hit;
  assign miss_inc = (state_q == ST_MISS) && mem_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_inc)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_inc) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_spiflash_cache.sv
// Scoreboard bench for spiflash_cache (DEPTH=4); stats checks when SPIFLASH_CACHE_STATS_EN is set.
module tb_spiflash_cache;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        resetn, valid, ready, flush, busy, mem_valid, mem_ready;
  logic [23:0] addr, mem_addr;
  logic [31:0] rdata, mem_rdata;
`ifdef SPIFLASH_CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  logic [23:0] exp_mem_q[$];
  int unsigned exp_hits   = 0;
  int unsigned exp_misses = 0;

  always #5 clk = ~clk;

  spiflash_cache #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .valid     (valid),
    .ready     (ready),
    .addr      (addr),
    .rdata     (rdata),
    .flush     (flush),
    .busy      (busy),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata)
`ifdef SPIFLASH_CACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mdata(input logic [23:0] a);
    return (a == 24'h000104) ? 32'hDEADBEEF : {8'h5A, a};
  endfunction

  // Monitor: every upstream response is popped against the scoreboard.
  always @(negedge clk) begin
    logic [31:0] e;
    if (resetn && ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ready: got rdata %h expected no response", rdata);
      end else begin
        e = exp_q.pop_front();
        check("rdata", rdata, e);
      end
    end
  end

  // Downstream responder: two cycles of latency, checks each request address.
  initial begin
    int lat;
    logic [23:0] ea;
    lat       = 0;
    mem_ready = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (mem_ready) begin
        mem_ready = 1'b0;
        lat       = 0;
      end else if (mem_valid) begin
        lat++;
        if (lat == 2) begin
          if (exp_mem_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_mem_req: got mem_addr %h expected no request", mem_addr);
          end else begin
            ea = exp_mem_q.pop_front();
            check("mem_addr", {8'h0, mem_addr}, {8'h0, ea});
          end
          mem_rdata = mdata(mem_addr);
          mem_ready = 1'b1;
        end
      end
    end
  end

  task automatic start_now(input logic [23:0] a, input logic [31:0] d, input bit miss);
    exp_q.push_back(d);
    if (miss) begin
      exp_mem_q.push_back({a[23:2], 2'b00});
      exp_misses++;
    end else begin
      exp_hits++;
    end
    addr  = a;
    valid = 1'b1;
  endtask

  task automatic start_req(input logic [23:0] a, input logic [31:0] d, input bit miss);
    @(negedge clk);
    start_now(a, d, miss);
  endtask

  task automatic wait_resp(output int lat);
    lat = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      lat++;
      if (ready) break;
    end
    if (!ready) begin
      checks++;
      failures++;
      $display("FAIL resp_timeout: got no ready after %0d cycles expected a response", lat);
    end
    valid = 1'b0;
  endtask

  task automatic req(input logic [23:0] a, input logic [31:0] d, input bit miss);
    int lat;
    start_req(a, d, miss);
    wait_resp(lat);
    if (!miss) check("hit_latency", 32'(lat), 32'd1);
  endtask

  task automatic count_sweep(input string name);
    int n;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (busy) n++;
      else if (n > 0) break;
    end
    check(name, 32'(n), 32'd4);
  endtask

  initial begin
    int n, rdy_err, lat;
    resetn = 1'b0;
    valid  = 1'b0;
    flush  = 1'b0;
    addr   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {31'h0, ready}, 32'd0);
    check("rst_busy", {31'h0, busy}, 32'd1);
    check("rst_mem_valid", {31'h0, mem_valid}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_addr", {8'h0, mem_addr}, 32'd0);

    // Release reset with a request already waiting; it must wait out the sweep.
    @(posedge clk);
    #1;
    resetn = 1'b1;
    start_now(24'h000104, 32'hDEADBEEF, 1'b1);
    n = 0;
    rdy_err = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (ready) rdy_err++;
    end
    check("init_busy_cycles", 32'(n), 32'd4);
    check("ready_during_sweep", 32'(rdy_err), 32'd0);
    wait_resp(lat);

    req(24'h000104, 32'hDEADBEEF, 1'b0);
    req(24'h000106, 32'hDEADBEEF, 1'b0);

    req(24'h000000, 32'h5A000000, 1'b1);
    req(24'h000010, 32'h5A000010, 1'b1);
    req(24'h000000, 32'h5A000000, 1'b1);

    // Flush while a miss is outstanding: fill still returns, then a sweep.
    start_req(24'h000020, 32'h5A000020, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_valid) break;
    end
    check("miss_mem_valid", {31'h0, mem_valid}, 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_resp(lat);
    count_sweep("flush_sweep_cycles");
`ifdef SPIFLASH_CACHE_STATS_EN
    check("hit_count_after_flush", hit_count, 32'(exp_hits));
    check("miss_count_after_flush", miss_count, 32'(exp_misses));
`endif
    req(24'h000020, 32'h5A000020, 1'b1);
    req(24'h000104, 32'hDEADBEEF, 1'b1);

    // Flush and valid together in IDLE: flush wins, request misses afterwards.
    start_req(24'h000104, 32'hDEADBEEF, 1'b1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    wait_resp(lat);
    req(24'h000104, 32'hDEADBEEF, 1'b0);

    repeat (5) @(negedge clk);
    check("pending_resp", 32'(exp_q.size()), 32'd0);
    check("pending_mem_req", 32'(exp_mem_q.size()), 32'd0);
`ifdef SPIFLASH_CACHE_STATS_EN
    check("hit_count", hit_count, 32'(exp_hits));
    check("miss_count", miss_count, 32'(exp_misses));
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1);
  end

endmodule

// File: doc/spiflash_cache.md
Name: spiflash_cache

Overview:
- Direct-mapped, word-granular read cache between the PicoRV32 memory interface and the SPI flash reader (spimemio) in PicoSoC.
- Hits return in 1 cycle.
- Misses forward one aligned word read downstream, fill the line, then respond.
- Supports full invalidation on reset and on an explicit flush pulse.

Parameters:
- DEPTH, 256, number of one-word lines; power of two, >=2. IDX_W = log2(DEPTH); TAG_W = 22-IDX_W.

Ports:
- clk  in  1  clock
- resetn  in  1  reset; asynchronous, active-low (already decided)
- valid  in  1  upstream read request; held until ready
- ready  out  1  upstream response strobe, one cycle
- addr  in  24  upstream byte address; addr[1:0] ignored
- rdata  out  32  upstream read data, valid while ready=1
- flush  in  1  invalidate-all request, single-cycle pulse
- busy  out  1  high during invalidation sweep or outstanding miss
- mem_valid  out  1  downstream request to spimemio
- mem_ready  in  1  downstream completion; may be combinational from mem_valid/mem_addr
- mem_addr  out  24  downstream word address, {addr[23:2],2'b00}
- mem_rdata  in  32  downstream data, valid with mem_ready

Behaviour:
- Address split: index = addr[IDX_W+1:2]; tag = addr[23:IDX_W+2].
- Storage per line: data[31:0], tag[TAG_W-1:0] (neither reset), plus a line-valid flop (cleared by the sweep).
- Reset values (async): ready=0, rdata=0, mem_valid=0, mem_addr=0, busy=1, state=INIT, sweep counter=0, flush_pending=0.
- INIT: clear one valid bit per cycle, index 0..DEPTH-1 (DEPTH cycles). Then go to IDLE and set busy=0. ready stays 0; valid is ignored.
- IDLE:
  - flush_pending=1 or flush=1: go to INIT, counter=0, clear flush_pending.
  - Else valid and hit: go to RESP with rdata=data[index].
  - Else valid and miss: go to MISS; set mem_valid=1, mem_addr=word address, busy=1.
- MISS:
  - mem_valid, mem_addr held stable until mem_ready.
  - At the edge with mem_ready=1: write data/tag, set the line valid, rdata=mem_rdata, mem_valid=0 in the following cycle, go to RESP.
  - Never abandons a downstream transaction.
- RESP: ready=1 for exactly one cycle. Then go to IDLE, busy=0. Valid is not resampled in RESP.
- Latency, valid sampled at edge N:
  - Hit: ready high in cycle N+1.
  - Miss: ready high the cycle after the mem_ready edge.
- Flush in INIT: restarts the sweep at index 0.
- Flush in MISS/RESP: sets flush_pending. The fill is still written and returned. The sweep starts on the next IDLE cycle, before any new lookup.
- Flush and valid in the same IDLE cycle: flush wins. The request stays pending and is served as a miss after the sweep.
- Upstream addr changing while valid is held is illegal; behaviour is unspecified.
- Reset mid-miss: mem_valid drops asynchronously. The downstream reader is reset by the same resetn.

Optional Feature:
- Macro SPIFLASH_CACHE_STATS_EN.
- Defined: adds ports hit_count out 32 and miss_count out 32.
  - Each increments once per RESP entered from a hit or from MISS, respectively.
  - Wrap at 2^32; reset to 0 asynchronously.
  - Not cleared by flush.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Package spiflash_cache_pkg:
  - state encoding ST_INIT=0, ST_IDLE=1, ST_MISS=2, ST_RESP=3 (2-bit);
  - constant ADDR_W=24;
  - function computing IDX_W from DEPTH.
- Sub-module spiflash_cache_ram: DEPTH x (32+TAG_W) array, asynchronous read by index, synchronous write enable. Valid bits remain in the top as flops so the sweep can clear them.

Test Plan:
- Reset release with DEPTH=4: busy=1 for exactly 4 cycles, then 0; a valid raised during the sweep gets ready only after it.
- Cold read: addr=0x000104 misses; mem_addr=0x000104; mem_ready with mem_rdata=0xDEADBEEF returns rdata=0xDEADBEEF. A repeat read of 0x000104 hits, with ready 1 cycle after valid and mem_valid staying 0.
- Conflict, DEPTH=4: read 0x000000 then 0x000010 (same index, different tag); both miss. Re-reading 0x000000 misses again.
- Byte offset: read 0x000106 after filling 0x000104 is a hit returning the same word.
- Flush during MISS: the fill completes and returns data, then a 4-cycle sweep runs. The next read of the same address misses.
- Stats build (SPIFLASH_CACHE_STATS_EN): the sequence miss, hit, hit, miss yields hit_count=2 and miss_count=2; a flush leaves both unchanged.
